// File: rtl/pipe_stage_elastic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg                                                             |
// | Shared state encoding and default widths for elastic pipe stages.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int CTRL_W_DEF = 8;
  localparam int DATA_W_DEF = 64;

  localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_elastic_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_elastic_if                                                |
// | valid/ready handshake carrying a control and a data bundle.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pipe_stage_elastic_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);

endinterface
`default_nettype wire

// File: rtl/pipe_stage_elastic_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_sat_counter                                                     |
// | Saturating event counter with synchronous clear (clear wins).        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_elastic                                                   |
// | Elastic pipeline register with optional 2-entry skid and flush.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush_i,
  input  logic                        clr_cnt_i,
  pipe_stage_elastic_if.slave         in_if,
  pipe_stage_elastic_if.master        out_if,
  output logic [CNT_W-1:0]            stall_cnt_o
);

  pipe_state_e       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic release_w;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_if.valid & in_ready;
  assign release_w = out_valid & out_if.ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      // Held data survives a flush; only validity is dropped.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_ctrl_d = in_if.ctrl;
            main_data_d = in_if.data;
          end
        end
        ONE: begin
          if (accept && release_w) begin
            main_ctrl_d = in_if.ctrl;
            main_data_d = in_if.data;
          end else if (accept) begin
            state_d     = TWO;
            skid_ctrl_d = in_if.ctrl;
            skid_data_d = in_if.data;
          end else if (release_w) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (release_w) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: upstream never sees a path from out_ready.
      logic in_ready_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != TWO);
        end
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = ~out_valid | out_if.ready;
    end
  endgenerate

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_if.data  = main_data_q;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (out_valid & ~out_if.ready),
    .clr_i (clr_cnt_i),
    .cnt_o (stall_cnt_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stage_elastic                                                |
// | Skid (CNT_W=4) and passthrough instances checked against a FIFO model.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [63:0] in_data = '0;
  logic [3:0]  cnt_s;
  logic [15:0] cnt_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic_if #(.CTRL_W(8), .DATA_W(64)) up_s ();
  pipe_stage_elastic_if #(.CTRL_W(8), .DATA_W(64)) dn_s ();
  pipe_stage_elastic_if #(.CTRL_W(8), .DATA_W(64)) up_n ();
  pipe_stage_elastic_if #(.CTRL_W(8), .DATA_W(64)) dn_n ();

  assign up_s.valid = in_valid;
  assign up_s.ctrl  = in_ctrl;
  assign up_s.data  = in_data;
  assign dn_s.ready = out_ready;
  assign up_n.valid = in_valid;
  assign up_n.ctrl  = in_ctrl;
  assign up_n.data  = in_data;
  assign dn_n.ready = out_ready;

  pipe_stage_elastic #(.CTRL_W(8), .DATA_W(64), .SKID(1), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .flush_i(flush), .clr_cnt_i(clr_cnt),
    .in_if(up_s), .out_if(dn_s), .stall_cnt_o(cnt_s));

  pipe_stage_elastic #(.CTRL_W(8), .DATA_W(64), .SKID(0), .CNT_W(16)) dut_n (
    .clk(clk), .reset(reset), .flush_i(flush), .clr_cnt_i(clr_cnt),
    .in_if(up_n), .out_if(dn_n), .stall_cnt_o(cnt_n));

  // Reference model: index 0 = skid instance, 1 = passthrough instance.
  int          n [2];
  logic [7:0]  mc [2][2];
  logic [63:0] md [2][2];
  logic [63:0] ml [2];
  int          mcnt [2];

  function automatic int cmax(int d);
    return (d == 0) ? 15 : 65535;
  endfunction

  function automatic bit m_ready(int d);
    if (d == 0) return (n[0] < 2);
    return (n[1] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      n[d] = 0; ml[d] = '0; mcnt[d] = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("valid_s", {63'd0, dn_s.valid}, {63'd0, n[0] > 0});
    chk("ctrl_s",  {56'd0, dn_s.ctrl},  (n[0] > 0) ? {56'd0, mc[0][0]} : 64'd0);
    chk("data_s",  dn_s.data, ml[0]);
    chk("cnt_s",   {60'd0, cnt_s}, 64'(mcnt[0]));
    chk("valid_n", {63'd0, dn_n.valid}, {63'd0, n[1] > 0});
    chk("ctrl_n",  {56'd0, dn_n.ctrl},  (n[1] > 0) ? {56'd0, mc[1][0]} : 64'd0);
    chk("data_n",  dn_n.data, ml[1]);
    chk("cnt_n",   {48'd0, cnt_n}, 64'(mcnt[1]));
  endtask

  task automatic tick();
    bit acc [2];
    bit rel [2];
    bit stl [2];
    #1;
    chk("rdy_s", {63'd0, up_s.ready}, {63'd0, m_ready(0)});
    chk("rdy_n", {63'd0, up_n.ready}, {63'd0, m_ready(1)});
    for (int d = 0; d < 2; d++) begin
      acc[d] = in_valid && m_ready(d);
      rel[d] = (n[d] > 0) && out_ready;
      stl[d] = (n[d] > 0) && !out_ready;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (clr_cnt) mcnt[d] = 0;
      else if (stl[d] && mcnt[d] < cmax(d)) mcnt[d]++;
      if (flush) begin
        n[d] = 0;
      end else begin
        if (rel[d]) begin
          mc[d][0] = mc[d][1]; md[d][0] = md[d][1]; n[d]--;
        end
        if (acc[d]) begin
          mc[d][n[d]] = in_ctrl; md[d][n[d]] = in_data; n[d]++;
        end
      end
      if (n[d] > 0) ml[d] = md[d][0];
    end
    #1;
    check_outs();
  endtask

  typedef struct {
    bit          v;
    logic [7:0]  c;
    logic [63:0] dat;
    bit          ordy;
    bit          fl;
    bit          e_rdy;
    bit          e_val;
    logic [7:0]  e_ctrl;
    logic [63:0] e_data;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // Streaming, backpressure into the skid entry, then flush with both held.
    tbl[0]  = '{1'b1, 8'h5A, 64'h1111, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 64'h1111, 4'd0};
    tbl[1]  = '{1'b1, 8'h3C, 64'h2222, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 64'h2222, 4'd0};
    tbl[2]  = '{1'b0, 8'h00, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 64'h2222, 4'd0};
    tbl[3]  = '{1'b1, 8'h11, 64'hAAAA, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 64'hAAAA, 4'd0};
    tbl[4]  = '{1'b1, 8'h22, 64'hBBBB, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 64'hAAAA, 4'd1};
    tbl[5]  = '{1'b1, 8'h33, 64'hCCCC, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 64'hAAAA, 4'd2};
    tbl[6]  = '{1'b1, 8'h33, 64'hCCCC, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 64'hAAAA, 4'd3};
    tbl[7]  = '{1'b1, 8'h33, 64'hCCCC, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 64'hBBBB, 4'd3};
    tbl[8]  = '{1'b1, 8'h33, 64'hCCCC, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 64'hCCCC, 4'd3};
    tbl[9]  = '{1'b0, 8'h00, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 64'hCCCC, 4'd3};
    tbl[10] = '{1'b1, 8'h44, 64'hDDDD, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 64'hDDDD, 4'd3};
    tbl[11] = '{1'b1, 8'h55, 64'hEEEE, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 64'hDDDD, 4'd4};
    tbl[12] = '{1'b1, 8'h66, 64'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 64'hDDDD, 4'd5};
    tbl[13] = '{1'b0, 8'h00, 64'h0,    1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 64'hDDDD, 4'd5};
    tbl[14] = '{1'b1, 8'h77, 64'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 64'h1234, 4'd5};
    tbl[15] = '{1'b0, 8'h00, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 64'h1234, 4'd5};

    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_valid", {63'd0, dn_s.valid}, 64'd0);
    chk("rst_ctrl",  {56'd0, dn_s.ctrl}, 64'd0);
    chk("rst_data",  dn_s.data, 64'd0);
    chk("rst_rdy",   {63'd0, up_s.ready}, 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      in_valid  = tbl[i].v;
      in_ctrl   = tbl[i].c;
      in_data   = tbl[i].dat;
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_rdy", i), {63'd0, up_s.ready}, {63'd0, tbl[i].e_rdy});
      tick();
      chk($sformatf("tbl%0d_val", i), {63'd0, dn_s.valid}, {63'd0, tbl[i].e_val});
      chk($sformatf("tbl%0d_ctrl", i), {56'd0, dn_s.ctrl}, {56'd0, tbl[i].e_ctrl});
      chk($sformatf("tbl%0d_data", i), dn_s.data, tbl[i].e_data);
      chk($sformatf("tbl%0d_cnt", i), {60'd0, cnt_s}, {60'd0, tbl[i].e_cnt});
    end
    flush = 1'b0;

    // Counter saturation and clear-while-stalled.
    in_valid = 1'b1; in_ctrl = 8'h88; in_data = 64'h8888; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_cnt", {60'd0, cnt_s}, 64'd15);
    clr_cnt = 1'b1;
    tick();
    chk("clr_cnt", {60'd0, cnt_s}, 64'd0);
    clr_cnt = 1'b0;
    tick();
    chk("resume_cnt", {60'd0, cnt_s}, 64'd1);
    out_ready = 1'b1;
    tick();
    tick();

    // Passthrough ready follows out_ready combinationally while full.
    in_valid = 1'b1; in_ctrl = 8'h91; in_data = 64'h9191;
    tick();
    in_ctrl = 8'h92; in_data = 64'h9292;
    out_ready = 1'b0;
    #1;
    chk("p0_rdy_lo", {63'd0, up_n.ready}, 64'd0);
    tick();
    chk("p0_hold", dn_n.data, 64'h9191);
    out_ready = 1'b1;
    #1;
    chk("p0_rdy_hi", {63'd0, up_n.ready}, 64'd1);
    tick();
    chk("p0_next", dn_n.data, 64'h9292);
    in_valid = 1'b0;
    tick();
    tick();

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      clr_cnt   = ($urandom_range(0, 29) == 0);
      in_ctrl   = 8'($urandom);
      in_data   = {$urandom, $urandom};
      tick();
    end
    flush = 1'b0; clr_cnt = 1'b0;

    // Asynchronous reset with two entries held.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0; in_ctrl = 8'hA1; in_data = 64'hA1A1;
    tick();
    in_ctrl = 8'hA2; in_data = 64'hA2A2;
    tick();
    chk("pre_rst_full", {63'd0, up_s.ready}, 64'd0);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_valid", {63'd0, dn_s.valid}, 64'd0);
    chk("arst_ctrl",  {56'd0, dn_s.ctrl}, 64'd0);
    chk("arst_data",  dn_s.data, 64'd0);
    chk("arst_cnt",   {60'd0, cnt_s}, 64'd0);
    chk("arst_rdy",   {63'd0, up_s.ready}, 64'd1);
    chk("arst_rdy_n", {63'd0, up_n.ready}, 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; in_ctrl = 8'hB1; in_data = 64'hB1B1;
    tick();
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised, elastic successor to the fixed ID/EX pipeline register, usable at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle under a valid/ready handshake.
- Optional 2-entry skid buffer breaks the combinational ready path.
- Flush converts all held contents to NOPs.
- Saturating stall counter supports performance debug.

Parameters:
- CTRL_W, 8, width of control bundle (RegWrite, MemRead, ...). All-zero means NOP.
- DATA_W, 64, width of data bundle (operands, imm, PC, register indices packed).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  block can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control to next stage; forced to 0 whenever out_valid=0.
- out_data  out  DATA_W  data to next stage; holds last value when invalid.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
- clr_cnt  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (async, active-high), all outputs: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0. in_ready=1 during and after reset. Skid entry invalid, and its ctrl and data are 0.
- Transfer definitions: accept = in_valid & in_ready; release = out_valid & out_ready.
- Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N.
- State machine for SKID=1; the state encoding is in the package.
  - EMPTY:
    - accept -> ONE.
  - ONE (main entry valid):
    - accept & release -> ONE; main takes the input.
    - accept & !release -> TWO; input goes to the skid entry.
    - !accept & release -> EMPTY.
    - Otherwise stay in ONE.
  - TWO (main and skid entries valid):
    - in_ready=0.
    - release -> ONE; main takes the skid entry.
    - Otherwise stay in TWO; both entries are held.
  - in_ready = (state != TWO), taken directly from a register with no combinational path from out_ready.
- SKID=0:
  - Single entry only.
  - in_ready = !out_valid | out_ready (combinational).
  - States are limited to EMPTY and ONE.
- Ordering is strict FIFO; no entry is duplicated or dropped except by flush.
- Flush:
  - Next state is EMPTY and out_valid=0.
  - out_ctrl reads 0 from the next cycle.
  - out_data and the skid data are not cleared.
  - An entry accepted in the same cycle as flush is discarded.
  - A release in the same cycle as flush still counts as completed downstream.
- Priority: reset > flush > normal operation.
- Stall behaviour:
  - With out_ready=0, out_ctrl and out_data are held stable while out_valid=1.
  - A bubble (no accept while EMPTY) yields out_ctrl=0.
- stall_cnt:
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - Priority: clr_cnt > increment; clr_cnt and increment in the same cycle -> 0.
  - flush does not clear stall_cnt.
- Reset mid-operation: all entries are lost immediately (async); there is no partial output.
- Width rules: ctrl and data are passed bit-exact; there is no arithmetic except the counter.

Decomposition:
- Package pipe_pkg:
  - Stage state enum {EMPTY, ONE, TWO}, 2 bits.
  - Localparam NOP_CTRL (all zero).
  - Default widths CTRL_W_DEF=8, DATA_W_DEF=64.
- Sub-module pipe_sat_counter (CNT_W; inc and clr inputs) for stall_cnt, reusable by other stages.
- Entry storage stays inline.

Test Plan:
- Reset: assert reset mid-stream with 2 entries held -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=1 asynchronously.
- Streaming: send A=(ctrl 0x5A, data 0x1111), then B=(0x3C, 0x2222) back-to-back with out_ready=1 -> A appears 1 cycle after acceptance, then B; in_ready stays 1.
- Backpressure (SKID=1): out_ready=0, send A, B, C -> A and B accepted and C blocked (in_ready=0 after B). Raise out_ready -> A, B, C delivered in order with no loss. stall_cnt equals the number of held cycles.
- Flush: hold A in main and B in skid, assert flush with C valid -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and A, B, C never appear.
- Counter saturation: CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt=15. Assert clr_cnt while still stalled -> 0, then counting resumes.
- SKID=0 passthrough: out_ready toggles 1,0,1 while in_valid is held -> in_ready follows !out_valid|out_ready combinationally and no entry is duplicated.
